// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: a captured 128-bit state is transformed
// COLS_PER_CYCLE columns per cycle and held until the downstream side takes it.

module inv_mix_col (
   input  logic [31:0] i_col,
   output logic [31:0] o_col
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // 9 = 8+1, b = 8+2+1, d = 8+4+1, e = 8+4+2
   function automatic logic [7:0] m9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction
   function automatic logic [7:0] mb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction
   function automatic logic [7:0] md(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction
   function automatic logic [7:0] me(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   logic [7:0] w_a0, w_a1, w_a2, w_a3;
   assign {w_a0, w_a1, w_a2, w_a3} = i_col;

   assign o_col = {me(w_a0) ^ mb(w_a1) ^ md(w_a2) ^ m9(w_a3),
                   m9(w_a0) ^ me(w_a1) ^ mb(w_a2) ^ md(w_a3),
                   md(w_a0) ^ m9(w_a1) ^ me(w_a2) ^ mb(w_a3),
                   mb(w_a0) ^ md(w_a1) ^ m9(w_a2) ^ me(w_a3)};
endmodule

module inv_mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]   r_state;
   logic [1:0]   r_col;
   logic [127:0] r_in;
   logic [127:0] r_res;

   logic [COLS_PER_CYCLE-1:0][1:0]  w_idx;
   logic [COLS_PER_CYCLE-1:0][1:0]  w_pos;
   logic [COLS_PER_CYCLE-1:0][31:0] w_col_in;
   logic [COLS_PER_CYCLE-1:0][31:0] w_col_out;
   logic [2:0]                      w_col_nxt;

   // Column 0 sits in the top word, so lane position is 3 - column index.
   for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
      assign w_idx[l]    = r_col + 2'(l);
      assign w_pos[l]    = 2'd3 - w_idx[l];
      assign w_col_in[l] = r_in[w_pos[l]*32 +: 32];
      inv_mix_col u_col (
         .i_col (w_col_in[l]),
         .o_col (w_col_out[l])
      );
   end

   assign w_col_nxt = {1'b0, r_col} + 3'(COLS_PER_CYCLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_col   <= 2'd0;
         r_in    <= '0;
         r_res   <= '0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_in    <= state_in;
               r_col   <= 2'd0;
               r_state <= BUSY;
            end
            BUSY: begin
               for (int l = 0; l < COLS_PER_CYCLE; l++)
                  r_res[w_pos[l]*32 +: 32] <= w_col_out[l];
               r_col <= w_col_nxt[1:0];
               // carry out of the counter marks the pass that wrote column 3
               if (w_col_nxt[2]) r_state <= DONE;
            end
            DONE: if (out_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == BUSY) || (r_state == DONE);
   assign state_out = r_res;
endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 The block SHALL have one parameter: COLS_PER_CYCLE, default 1, number of columns transformed per BUSY cycle; legal values 1, 2, 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: state_in carries a valid 128-bit AES state.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-006 The block SHALL have port state_in, input, 128 bits: column-major AES state; bits [127:96] hold column 0 and [31:0] hold column 3; bits [127:120] hold row 0 of column 0.
REQ-007 The block SHALL have port out_valid, output, 1 bit: state_out holds a finished result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream block accepts state_out.
REQ-009 The block SHALL have port state_out, output, 128 bits: the InvMixColumns result, in the same byte layout as state_in.
REQ-010 The block SHALL have port busy, output, 1 bit: high in BUSY and DONE.

Function
REQ-011 The block SHALL compute the AES InvMixColumns function independently on each column, using the matrix rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
REQ-012 GF(2^8) multiplication SHALL use reduction polynomial 0x11B (xtime: shift left by 1, XOR 0x1B if bit 7 was set); sums SHALL be XOR; all intermediate values SHALL be 8 bits.
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE: in_ready=1, out_valid=0, busy=0.
REQ-015 A transfer SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; on that edge state_in SHALL be captured into an internal register and the FSM SHALL move IDLE->BUSY with the column counter set to 0.
REQ-016 After acceptance, state_in SHALL be don't-care; the result SHALL depend only on the captured value.
REQ-017 In BUSY, each rising edge SHALL transform COLS_PER_CYCLE consecutive columns, starting at the counter value, write them into the result register, and advance the counter by COLS_PER_CYCLE.
REQ-018 The edge that transforms column 3 SHALL move the FSM BUSY->DONE.
REQ-019 BUSY SHALL therefore last N = 4/COLS_PER_CYCLE cycles, and out_valid SHALL first be high N cycles after the acceptance edge.
REQ-020 In BUSY: in_ready=0, out_valid=0.
REQ-021 In DONE: out_valid=1, in_ready=0, and state_out SHALL hold the full result, stable until the result is consumed.
REQ-022 On a rising edge in DONE with out_ready=1, the FSM SHALL move DONE->IDLE; out_ready=0 SHALL hold DONE indefinitely (backpressure).
REQ-023 No input SHALL be accepted on the edge that consumes the output; the next acceptance is possible at the earliest one cycle later, so the throughput is one state per N+2 cycles.
REQ-024 in_valid asserted while in BUSY or DONE SHALL be ignored and SHALL NOT corrupt the result.
REQ-025 out_ready asserted outside DONE SHALL have no effect.
REQ-026 state_out SHALL be driven from a register; its value outside DONE is unspecified but SHALL NOT be X after reset.

Reset
REQ-027 While rst=1: FSM=IDLE, counter=0, input and result registers=0, in_ready=1, out_valid=0, busy=0, state_out=0.
REQ-028 Asserting rst during BUSY or DONE SHALL abort the operation immediately, discard the partial result, and SHALL NOT raise out_valid after rst is released.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst is released.

Verification
REQ-030 Test known-answer columns: with state_in = 8e4da1bc_9fdc589d_01010101_d5d5d7d6, state_out SHALL be db135345_f20a225c_01010101_d4d4d4d5, with out_valid first high exactly N cycles after acceptance, for COLS_PER_CYCLE = 1, 2 and 4.
REQ-031 Test the round trip: 1000 random states are passed through a reference forward MixColumns and then fed to this block; each output SHALL equal the original state, and state_in SHALL be randomised after acceptance.
REQ-032 Test backpressure: with out_ready held at 0 for 20 cycles in DONE, state_out and out_valid SHALL remain stable, in_ready SHALL remain 0, and in_valid pulses SHALL be ignored; with out_ready=1, the next cycle SHALL be IDLE with in_ready=1.
REQ-033 Test reset mid-operation: rst pulsed for one cycle during the 2nd BUSY cycle with COLS_PER_CYCLE=1 SHALL give immediate IDLE outputs and no out_valid afterwards; a following transfer of 4d7ebdf8 in all columns SHALL return 2d26314c in all columns.
REQ-034 Test corner values: all-zero state -> all-zero output; c6c6c6c6 in all columns -> c6c6c6c6 unchanged; back-to-back transfers with in_valid held high SHALL be spaced exactly N+2 cycles apart.
